// File: rtl/id_hazard_ctrl.sv
// ID/EX consumer-side hazard controller: RAW scoreboard,
// EX redirect flush and HALT drain sequencing.
module id_hazard_ctrl #(
    parameter int DEPTH       = 3,
    parameter int BYPASS_WB   = 0,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [2:0]             id_rs,
    input  logic                   id_rs_used,
    input  logic [2:0]             id_rt,
    input  logic                   id_rt_used,
    input  logic                   id_regwrt,
    input  logic [2:0]             id_write_reg,
    input  logic                   id_halt,
    input  logic                   ex_redirect,
    output logic                   stall,
    output logic                   bubble,
    output logic                   flush_ifid,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_count,
    output logic [7:0]             sb_busy
);

    localparam int CW   = $clog2(DEPTH) + 1;
    localparam int NCMP = (BYPASS_WB != 0) ? DEPTH - 1 : DEPTH;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   drain_cnt;
    logic [CW-1:0]   drain_cnt_nxt;
    logic [DEPTH-1:0] sb_v;
    logic [2:0]      sb_r [DEPTH];
    logic            match_rs;
    logic            match_rt;
    logic            hazard;
    logic            accept;

    // Compare decode sources against the older in-flight destinations
    always_comb begin
        match_rs = 1'b0;
        match_rt = 1'b0;
        for (int i = 0; i < NCMP; i++) begin
            if (sb_v[i] && sb_r[i] == id_rs) match_rs = 1'b1;
            if (sb_v[i] && sb_r[i] == id_rt) match_rt = 1'b1;
        end
        hazard = id_valid &
                 ((id_rs_used & match_rs) | (id_rt_used & match_rt));
    end

    // One-hot summary of every valid destination in flight
    always_comb begin
        sb_busy = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            if (sb_v[i]) sb_busy[sb_r[i]] = 1'b1;
        end
    end

    // Next state and per-state pipeline control
    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        stall         = 1'b0;
        bubble        = 1'b0;
        flush_ifid    = 1'b0;
        halted        = 1'b0;
        accept        = 1'b0;
        unique case (state)
            RUN: begin
                if (ex_redirect) begin
                    bubble     = 1'b1;
                    flush_ifid = 1'b1;
                end else if (hazard) begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                end
                accept = id_valid & ~ex_redirect & ~hazard;
                if (accept && id_halt) begin
                    state_nxt     = DRAIN;
                    drain_cnt_nxt = '0;
                end
            end
            DRAIN: begin
                stall         = 1'b1;
                bubble        = 1'b1;
                drain_cnt_nxt = drain_cnt + 1'b1;
                if (drain_cnt == CW'(DEPTH - 1)) state_nxt = HALTED;
            end
            HALTED: begin
                stall  = 1'b1;
                bubble = 1'b1;
                halted = 1'b1;
            end
            default: state_nxt = RUN;
        endcase
    end

    // State and drain counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    // Shift the scoreboard one stage; bubbles enter as invalid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_v <= '0;
            for (int i = 0; i < DEPTH; i++) sb_r[i] <= 3'd0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                sb_v[i] <= sb_v[i-1];
                sb_r[i] <= sb_r[i-1];
            end
            sb_v[0] <= accept & id_regwrt;
            sb_r[0] <= (accept & id_regwrt) ? id_write_reg : 3'd0;
        end
    end

    // Saturating count of hazard stalls seen while running
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
        end else if (state == RUN && stall && !(&stall_count)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: directed vector table, corner
// sequences and random stimulus against a cycle-history model.
module tb_id_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       id_valid, id_rs_used, id_rt_used, id_regwrt;
    logic       id_halt, ex_redirect;
    logic [2:0] id_rs, id_rt, id_write_reg;
    logic [1:0] st, bu, fl, ha;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;
    logic [7:0]  busy0, busy1;

    always #5 clk = ~clk;

    id_hazard_ctrl #(.DEPTH(3), .BYPASS_WB(0), .STALL_CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
        .id_regwrt(id_regwrt), .id_write_reg(id_write_reg),
        .id_halt(id_halt), .ex_redirect(ex_redirect), .stall(st[0]),
        .bubble(bu[0]), .flush_ifid(fl[0]), .halted(ha[0]),
        .stall_count(cnt0), .sb_busy(busy0));

    id_hazard_ctrl #(.DEPTH(3), .BYPASS_WB(1), .STALL_CNT_W(4)) u1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
        .id_regwrt(id_regwrt), .id_write_reg(id_write_reg),
        .id_halt(id_halt), .ex_redirect(ex_redirect), .stall(st[1]),
        .bubble(bu[1]), .flush_ifid(fl[1]), .halted(ha[1]),
        .stall_count(cnt1), .sb_busy(busy1));

    int errors = 0;
    int checks = 0;

    // Model: per cycle since reset, the destination accepted (-1 none)
    int wr [2][1024];
    int halt_c [2];
    int cnt [2];
    int now;
    int cmax [2] = '{65535, 15};
    int win [2] = '{3, 2};
    int p_wr [2];
    bit p_h [2];
    bit p_c [2];

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic model_reset();
        now = 0;
        for (int k = 0; k < 2; k++) begin
            halt_c[k] = -1;
            cnt[k] = 0;
        end
    endtask

    function automatic void model_out(input int k,
        output logic e_st, output logic e_bu, output logic e_fl,
        output logic e_ha, output logic [7:0] e_busy,
        output logic e_run);
        int s;
        int c;
        logic hz;
        e_busy = 8'h00;
        hz = 1'b0;
        if (halt_c[k] < 0) s = 0;
        else if (now > halt_c[k] + 3) s = 2;
        else s = 1;
        for (int d = 1; d <= 3; d++) begin
            c = now - d;
            if (c >= 0 && wr[k][c] >= 0) begin
                e_busy[wr[k][c]] = 1'b1;
                if (d <= win[k] && id_valid &&
                    ((id_rs_used && wr[k][c] == int'(id_rs)) ||
                     (id_rt_used && wr[k][c] == int'(id_rt))))
                    hz = 1'b1;
            end
        end
        e_run = (s == 0);
        e_ha  = (s == 2);
        e_fl  = (s == 0) && ex_redirect;
        e_st  = (s != 0) || (!ex_redirect && hz);
        e_bu  = (s != 0) || ex_redirect || hz;
    endfunction

    task automatic step_a(input string tag);
        logic e_st, e_bu, e_fl, e_ha, e_run;
        logic [7:0] e_busy;
        logic acc;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            model_out(k, e_st, e_bu, e_fl, e_ha, e_busy, e_run);
            chk($sformatf("%s stall%0d", tag, k), 32'(st[k]), 32'(e_st));
            chk($sformatf("%s bubble%0d", tag, k), 32'(bu[k]), 32'(e_bu));
            chk($sformatf("%s flush%0d", tag, k), 32'(fl[k]), 32'(e_fl));
            chk($sformatf("%s halted%0d", tag, k), 32'(ha[k]), 32'(e_ha));
            chk($sformatf("%s busy%0d", tag, k),
                k == 0 ? 32'(busy0) : 32'(busy1), 32'(e_busy));
            chk($sformatf("%s count%0d", tag, k),
                k == 0 ? 32'(cnt0) : 32'(cnt1), 32'(cnt[k]));
            acc = e_run && id_valid && !e_st && !e_bu;
            p_wr[k] = (acc && id_regwrt) ? int'(id_write_reg) : -1;
            p_h[k] = acc && id_halt;
            p_c[k] = e_run && e_st;
        end
    endtask

    task automatic step_b();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            wr[k][now] = p_wr[k];
            if (p_h[k]) halt_c[k] = now;
            if (p_c[k] && cnt[k] < cmax[k]) cnt[k]++;
        end
        now++;
        #1;
    endtask

    task automatic drive(input int v, input int rs, input int rsu,
                         input int rt, input int rtu, input int wrt,
                         input int wd, input int h, input int rd);
        id_valid = v[0];
        id_rs = rs[2:0];
        id_rs_used = rsu[0];
        id_rt = rt[2:0];
        id_rt_used = rtu[0];
        id_regwrt = wrt[0];
        id_write_reg = wd[2:0];
        id_halt = h[0];
        ex_redirect = rd[0];
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst stall", 32'(st), 32'd0);
        chk("rst bubble", 32'(bu), 32'd0);
        chk("rst flush", 32'(fl), 32'd0);
        chk("rst halted", 32'(ha), 32'd0);
        chk("rst busy", 32'({busy0, busy1}), 32'd0);
        chk("rst count", 32'({cnt0, cnt1}), 32'd0);
        model_reset();
        rst = 1'b1;
    endtask

    typedef struct {
        int v, rs, rsu, rt, rtu, wrt, wd, h, rd;
        logic [3:0] e4;
        logic [7:0] eb;
        logic e1;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mkv(input int v, input int rs,
        input int rsu, input int rt, input int rtu, input int wrt,
        input int wd, input int h, input int rd, input logic [3:0] e4,
        input logic [7:0] eb, input logic e1);
        vec_t r;
        r.v = v; r.rs = rs; r.rsu = rsu; r.rt = rt; r.rtu = rtu;
        r.wrt = wrt; r.wd = wd; r.h = h; r.rd = rd;
        r.e4 = e4; r.eb = eb; r.e1 = e1;
        return r;
    endfunction

    initial begin
        // e4 = {stall, bubble, flush, halted} of the BYPASS_WB=0 unit
        tbl[0]  = mkv(1, 0, 0, 0, 0, 1, 3, 0, 0, 4'b0000, 8'h00, 1'b0);
        tbl[1]  = mkv(1, 3, 1, 0, 0, 0, 0, 0, 0, 4'b1100, 8'h08, 1'b1);
        tbl[2]  = mkv(1, 3, 1, 0, 0, 0, 0, 0, 0, 4'b1100, 8'h08, 1'b1);
        tbl[3]  = mkv(1, 3, 1, 0, 0, 0, 0, 0, 0, 4'b1100, 8'h08, 1'b0);
        tbl[4]  = mkv(1, 3, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 8'h00, 1'b0);
        tbl[5]  = mkv(1, 0, 0, 0, 0, 1, 5, 0, 0, 4'b0000, 8'h00, 1'b0);
        tbl[6]  = mkv(1, 0, 0, 5, 0, 1, 2, 0, 0, 4'b0000, 8'h20, 1'b0);
        tbl[7]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 8'h24, 1'b0);
        tbl[8]  = mkv(1, 2, 1, 0, 0, 1, 7, 0, 0, 4'b1100, 8'h24, 1'b1);
        tbl[9]  = mkv(1, 2, 1, 0, 0, 1, 7, 1, 1, 4'b0110, 8'h04, 1'b0);
        tbl[10] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 8'h00, 1'b0);
        tbl[11] = mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 8'h00, 1'b0);
        tbl[12] = mkv(1, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 8'h00, 1'b0);
        tbl[13] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 8'h00, 1'b1);
        tbl[14] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b1100, 8'h00, 1'b1);
        tbl[15] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 8'h00, 1'b1);
        tbl[16] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1101, 8'h00, 1'b1);
        tbl[17] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1101, 8'h00, 1'b1);

        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].v, tbl[i].rs, tbl[i].rsu, tbl[i].rt, tbl[i].rtu,
                  tbl[i].wrt, tbl[i].wd, tbl[i].h, tbl[i].rd);
            step_a($sformatf("vec%0d", i));
            chk($sformatf("vec%0d tbl ctl", i),
                32'({st[0], bu[0], fl[0], ha[0]}), 32'(tbl[i].e4));
            chk($sformatf("vec%0d tbl busy", i), 32'(busy0), 32'(tbl[i].eb));
            chk($sformatf("vec%0d tbl stall_wb", i), 32'(st[1]),
                32'(tbl[i].e1));
            if (i == 5) begin
                chk("raw count", 32'(cnt0), 32'd3);
                chk("raw count bypass", 32'(cnt1), 32'd2);
            end
            step_b();
        end

        // Asynchronous reset in the middle of a drain
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 4, 1, 0);
        step_a("rdrain c0");
        step_b();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step_a("rdrain c1");
        step_b();
        #2;
        rst = 1'b0;
        #1;
        chk("async stall", 32'(st), 32'd0);
        chk("async halted", 32'(ha), 32'd0);
        chk("async busy", 32'({busy0, busy1}), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1, 0, 0, 0, 0, 1, 1, 0, 0);
        step_a("post rst");
        step_b();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step_a("post rst next");
        chk("post rst busy", 32'(busy0), 32'h02);
        step_b();

        // Repeated producer/consumer pairs to saturate the 4-bit counter
        do_reset();
        for (int r = 0; r < 10; r++) begin
            drive(1, 0, 0, 0, 0, 1, 1, 0, 0);
            step_a("sat prod");
            step_b();
            drive(1, 1, 1, 0, 0, 0, 0, 0, 0);
            for (int j = 0; j < 4; j++) begin
                step_a("sat cons");
                step_b();
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step_a("sat end");
        chk("sat count4", 32'(cnt1), 32'd15);
        chk("sat count16", 32'(cnt0), 32'd30);
        step_b();

        // Random traffic over a small register set
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            for (int c = 0; c < 64; c++) begin
                drive(int'($urandom_range(3) != 0), int'($urandom_range(3)),
                      int'($urandom_range(1)), int'($urandom_range(3)),
                      int'($urandom_range(1)), int'($urandom_range(1)),
                      int'($urandom_range(3)),
                      int'($urandom_range(47) == 0),
                      int'($urandom_range(7) == 0));
                step_a($sformatf("rnd%0d.%0d", seg, c));
                step_b();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
- Consumer-side controller for the ID/EX pipeline register. It decides each cycle whether the decoded instruction may enter ID/EX, or whether decode must stall and a bubble be injected.
- Keeps a shift-register scoreboard of destination registers in flight in EX, MEM and WB, and detects RAW hazards against decode sources (no forwarding in this pipeline).
- Also handles EX-stage redirect flushes and the halt drain sequence.

Parameters:
- DEPTH, 3, number of in-flight stages tracked (EX, MEM, WB).
- BYPASS_WB, 0, 1 means the register file writes before it reads, so the WB entry is excluded from hazard compare.
- STALL_CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- id_valid  in  1  decode holds a valid instruction.
- id_rs  in  3  source register 1.
- id_rs_used  in  1  source 1 is read.
- id_rt  in  3  source register 2.
- id_rt_used  in  1  source 2 is read.
- id_regwrt  in  1  decoded instruction writes the register file.
- id_write_reg  in  3  decoded destination register.
- id_halt  in  1  decoded instruction is HALT.
- ex_redirect  in  1  branch or jump resolved taken in EX this cycle.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  zero the ID/EX control inputs (RegWrt, MemWrt, branch, halt).
- flush_ifid  out  1  invalidate IF/ID on the next edge.
- halted  out  1  pipeline drained after HALT.
- stall_count  out  STALL_CNT_W  saturating count of hazard-stall cycles.
- sb_busy  out  8  one-hot OR of the destinations of all valid scoreboard entries.

Behaviour:
- Reset (rst=0, async):
  - All scoreboard entries invalid; state=RUN; stall_count=0.
  - Outputs are then stall=0, bubble=0, flush_ifid=0, halted=0, sb_busy=0.
- Scoreboard: entries e[0]=EX .. e[DEPTH-1]=WB, each holding {valid, reg[2:0]}. On every clock edge, e[i] takes e[i-1] for i>=1.
  - e[0] becomes {1, id_write_reg} if accept & id_regwrt, otherwise {0, 0}.
- hazard = id_valid & ((id_rs_used & match(id_rs)) | (id_rt_used & match(id_rt))).
  - match(r) is true when any valid e[i] has reg==r, for i < DEPTH, or i < DEPTH-1 when BYPASS_WB=1.
- States: RUN, DRAIN (with a counter of ceil(log2(DEPTH))+1 bits), HALTED.
- RUN outputs, combinational from inputs and state:
  - ex_redirect=1 → stall=0, bubble=1, flush_ifid=1. Redirect overrides the hazard. The ID instruction is wrong-path and is not accepted; any HALT in ID is discarded.
  - else hazard → stall=1, bubble=1, flush_ifid=0.
  - else → stall=0, bubble=0, flush_ifid=0.
- accept = (state==RUN) & id_valid & ~stall & ~bubble.
- RUN→DRAIN on an edge where accept & id_halt; the counter loads 0.
- DRAIN: stall=1, bubble=1, flush_ifid=0; the counter increments each cycle. ex_redirect is ignored, since no older branch can still be in EX.
  - When counter==DEPTH-1, the next state is HALTED.
- HALTED: stall=1, bubble=1, halted=1. Held until reset.
- stall_count increments on each edge where state==RUN & stall=1. It saturates at all-ones and does not count DRAIN or HALTED cycles.
- Bubbled cycles shift an invalid entry into e[0]. A hazard therefore clears exactly when the producer exits the compared window.
- Reset asserted mid-stall or mid-drain clears everything immediately, with no partial state kept.
- A source register equal to the decoded instruction's own destination does not self-hazard, because compare uses only older entries.

Test Plan:
- RAW stall, BYPASS_WB=0: accept a write to r3 at cycle 0; present id_rs=3, id_rs_used=1 from cycle 1 → stall=bubble=1 on cycles 1-3, released on cycle 4, stall_count=3. With BYPASS_WB=1 → stall on cycles 1-2, stall_count=2.
- Unused source: accept a write to r5, then id_rt=5 with id_rt_used=0 → stall=0, accept, sb_busy shows bits 5 and the new destination.
- Redirect over hazard: hazard pending, then ex_redirect=1 → stall=0, bubble=1, flush_ifid=1, and e[0] is invalid on the next cycle. A HALT in ID in the same cycle → state stays RUN.
- Halt drain, DEPTH=3: accept HALT at the cycle-0 edge → cycles 1-3 DRAIN with stall=bubble=1 and halted=0; halted=1 from cycle 4 onward. ex_redirect pulsed on cycle 2 has no effect.
- Async reset mid-DRAIN: drop rst on cycle 2, between edges → halted=0, stall=0, sb_busy=0 immediately. After release, a new instruction is accepted next cycle.
- Counter saturation, STALL_CNT_W=4: hold a hazard for 20 RUN cycles via repeated producers → stall_count stops at 15.
